// File: rtl/demux1to2_deser_if.sv
// Stream bundle for demux1to2_deser: serial bit input on one side, H/G word-pair output on the other.
// The slave modport is the deserialiser's view; the master modport is the producer/consumer view.
interface demux1to2_deser_if #(
  parameter int WIDTH = 4
);
  logic             din;
  logic             din_valid;
  logic             din_ready;
  logic             sel;
  logic [WIDTH-1:0] h_out;
  logic [WIDTH-1:0] g_out;
  logic             out_valid;
  logic             out_ready;
  logic             perr;

  modport master (
    output din, din_valid, out_ready,
    input  din_ready, sel, h_out, g_out, out_valid, perr
  );

  modport slave (
    input  din, din_valid, out_ready,
    output din_ready, sel, h_out, g_out, out_valid, perr
  );
endinterface

// File: rtl/demux1to2_deser.sv
// 1:2 serial demux/deserialiser: even bits build the H word, odd bits the G word, LSB-first.
// Define DEMUX_PARITY_CHK_EN to append one even-parity bit per frame and report it on perr.
module demux1to2_deser #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  demux1to2_deser_if.slave   bus
);

`ifdef DEMUX_PARITY_CHK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  localparam int NDATA = 2 * WIDTH;
  localparam int NBITS = NDATA + (PAR_EN ? 1 : 0);
  localparam int CW    = $clog2(NBITS + 1);

  typedef enum logic {COLLECT, FULL} state_t;

  state_t           r_state, w_stateNext;
  logic [CW-1:0]    r_cnt, w_cntNext;
  logic             r_sel, w_selNext;
  logic [WIDTH-1:0] r_hSh, r_gSh, w_hShNext, w_gShNext;
  logic [WIDTH-1:0] r_h, r_g, w_hNext, w_gNext;
  logic [WIDTH-1:0] w_hIns, w_gIns;
  logic             r_par, w_parNext, w_parIns;
  logic             r_valid, w_validNext;
  logic             r_perr, w_perrNext;
  logic             w_accept, w_isData, w_last, w_outFree;

  assign bus.din_ready = (r_state == COLLECT) && !rst;
  assign w_accept      = bus.din_valid && bus.din_ready;
  assign w_isData      = r_cnt < CW'(NDATA);
  assign w_last        = r_cnt == CW'(NBITS - 1);
  assign w_outFree     = !r_valid || bus.out_ready;

  // Shift registers including the bit on the wire, so a finishing frame can load the output directly.
  assign w_hIns   = (w_isData && !r_sel) ? {bus.din, r_hSh[WIDTH-1:1]} : r_hSh;
  assign w_gIns   = (w_isData &&  r_sel) ? {bus.din, r_gSh[WIDTH-1:1]} : r_gSh;
  assign w_parIns = r_par ^ bus.din;

  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_selNext   = r_sel;
    w_hShNext   = r_hSh;
    w_gShNext   = r_gSh;
    w_parNext   = r_par;
    w_hNext     = r_h;
    w_gNext     = r_g;
    w_perrNext  = r_perr;
    w_validNext = r_valid && !bus.out_ready;
    unique case (r_state)
      COLLECT: begin
        if (w_accept) begin
          w_hShNext = w_hIns;
          w_gShNext = w_gIns;
          w_parNext = w_parIns;
          w_selNext = w_isData ? !r_sel : r_sel;
          w_cntNext = r_cnt + CW'(1);
          if (w_last) begin
            w_cntNext = '0;
            w_selNext = 1'b0;
            if (w_outFree) begin
              w_hNext     = w_hIns;
              w_gNext     = w_gIns;
              w_perrNext  = w_parIns;
              w_validNext = 1'b1;
              w_parNext   = 1'b0;
            end else begin
              w_stateNext = FULL;
            end
          end
        end
      end
      FULL: begin
        // Output is necessarily occupied here; swap in the held frame as the old one leaves.
        if (bus.out_ready) begin
          w_hNext     = r_hSh;
          w_gNext     = r_gSh;
          w_perrNext  = r_par;
          w_validNext = 1'b1;
          w_parNext   = 1'b0;
          w_stateNext = COLLECT;
        end
      end
      default: w_stateNext = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= COLLECT;
      r_cnt   <= '0;
      r_sel   <= 1'b0;
      r_hSh   <= '0;
      r_gSh   <= '0;
      r_par   <= 1'b0;
      r_h     <= '0;
      r_g     <= '0;
      r_perr  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
      r_sel   <= w_selNext;
      r_hSh   <= w_hShNext;
      r_gSh   <= w_gShNext;
      r_par   <= w_parNext;
      r_h     <= w_hNext;
      r_g     <= w_gNext;
      r_perr  <= w_perrNext;
      r_valid <= w_validNext;
    end
  end

  assign bus.sel       = r_sel;
  assign bus.h_out     = r_h;
  assign bus.g_out     = r_g;
  assign bus.out_valid = r_valid;
  assign bus.perr      = PAR_EN ? r_perr : 1'b0;

endmodule

// File: tb/tb_demux1to2_deser.sv
// Self-checking bench for demux1to2_deser: directed scenarios plus randomized frames with random
// backpressure, scored against a frame-level model of the bit-steering rules.
module tb_demux1to2_deser;

`ifdef DEMUX_PARITY_CHK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  localparam int W     = 4;
  localparam int NDATA = 2 * W;
  localparam int NB    = NDATA + (PAR_EN ? 1 : 0);

  typedef struct {
    logic [W-1:0] h;
    logic [W-1:0] g;
    logic         p;
  } frame_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  demux1to2_deser_if #(.WIDTH(W)) bus ();

  demux1to2_deser #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;
  int cycle   = 0;

  frame_t           expQ[$];
  int               tq[$];
  logic [NDATA:0]   bitsVec = '0;
  int               k = 0;
  int               stallCnt = 0;
  int               xferCnt = 0;
  bit               doneRand = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  // Frame bit i goes to H bit i/2 when i is even, G bit i/2 when odd; perr is the overall XOR.
  function automatic frame_t buildFrame(input logic [NDATA-1:0] data, input logic par);
    frame_t f;
    f.h = '0;
    f.g = '0;
    for (int i = 0; i < NDATA; i++) begin
      if (i % 2 == 0) f.h[i/2] = data[i];
      else            f.g[i/2] = data[i];
    end
    f.p = PAR_EN ? ((^data) ^ par) : 1'b0;
    return f;
  endfunction

  always @(posedge clk) cycle++;

  // Reference monitor: scores every presented frame and the steering bit, and collects accepted bits.
  always @(negedge clk) begin
    if (rst) begin
      expQ.delete();
      k = 0;
    end else begin
      if (bus.out_valid) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_valid", 32'(bus.out_valid), 32'd0);
        end else begin
          checkOutput("h_out", 32'(bus.h_out), 32'(expQ[0].h));
          checkOutput("g_out", 32'(bus.g_out), 32'(expQ[0].g));
          checkOutput("perr",  32'(bus.perr),  32'(expQ[0].p));
          if (bus.out_ready) begin
            void'(expQ.pop_front());
            tq.push_back(cycle);
            xferCnt++;
          end
        end
      end
      checkOutput("sel", 32'(bus.sel), (k < NDATA) ? 32'(k % 2) : 32'd0);
      if (bus.din_valid && bus.din_ready) begin
        bitsVec[k] = bus.din;
        k++;
        if (k == NB) begin
          expQ.push_back(buildFrame(bitsVec[NDATA-1:0], bitsVec[NDATA]));
          k = 0;
        end
      end else if (bus.din_valid) begin
        stallCnt++;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the edge that accepted the bit.
  task automatic applyStimulus(input logic b, input int gaps);
    bit acc = 1'b0;
    int n = 0;
    bus.din_valid = 1'b0;
    repeat (gaps) begin
      @(posedge clk);
      #1;
    end
    bus.din       = b;
    bus.din_valid = 1'b1;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = bus.din_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) checkOutput("accept_timeout", 32'd0, 32'd1);
    bus.din_valid = 1'b0;
  endtask

  task automatic sendFrame(input logic [NDATA-1:0] data, input logic par, input int minGap, input int maxGap);
    for (int i = 0; i < NDATA; i++)
      applyStimulus(data[i], int'($urandom_range(maxGap, minGap)));
    if (PAR_EN) applyStimulus(par, int'($urandom_range(maxGap, minGap)));
  endtask

  task automatic idleCycles(input int n);
    bus.din_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    frame_t fa, fb;
    logic [NDATA-1:0] da, db, dr;
    int stallBase, tqBase, xferBase;

    bus.din       = 1'b0;
    bus.din_valid = 1'b0;
    bus.out_ready = 1'b0;

    #7;
    checkOutput("rst_din_ready", 32'(bus.din_ready), 32'd0);
    checkOutput("rst_sel",       32'(bus.sel),       32'd0);
    checkOutput("rst_h",         32'(bus.h_out),     32'd0);
    checkOutput("rst_g",         32'(bus.g_out),     32'd0);
    checkOutput("rst_valid",     32'(bus.out_valid), 32'd0);
    checkOutput("rst_perr",      32'(bus.perr),      32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] basic frame 1,0,1,1,0,0,1,0");
    bus.out_ready = 1'b1;
    sendFrame(8'b01001101, 1'b0, 0, 0);
    checkOutput("t1_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("t1_h",     32'(bus.h_out),     32'hB);
    checkOutput("t1_g",     32'(bus.g_out),     32'h2);
    checkOutput("t1_perr",  32'(bus.perr),      32'd0);
    sendFrame(8'b01001101, 1'b1, 0, 0);
    checkOutput("t1p_h",    32'(bus.h_out),     32'hB);
    checkOutput("t1p_g",    32'(bus.g_out),     32'h2);
    checkOutput("t1p_perr", 32'(bus.perr),      PAR_EN ? 32'd1 : 32'd0);
    idleCycles(2);

    $display("[TB] back-to-back frames");
    stallBase = stallCnt;
    tqBase    = tq.size();
    sendFrame(NDATA'($urandom), 1'($urandom), 0, 0);
    sendFrame(NDATA'($urandom), 1'($urandom), 0, 0);
    idleCycles(3);
    checkOutput("b2b_stalls", 32'(stallCnt - stallBase), 32'd0);
    checkOutput("b2b_count",  32'(tq.size() - tqBase),   32'd2);
    if (tq.size() - tqBase == 2)
      checkOutput("b2b_spacing", 32'(tq[tqBase+1] - tq[tqBase]), 32'(NB));

    $display("[TB] backpressure");
    bus.out_ready = 1'b0;
    da = NDATA'($urandom);
    db = ~da;
    fa = buildFrame(da, 1'b0);
    fb = buildFrame(db, 1'b1);
    sendFrame(da, 1'b0, 0, 0);
    sendFrame(db, 1'b1, 0, 0);
    checkOutput("bp_din_ready", 32'(bus.din_ready), 32'd0);
    checkOutput("bp_h_hold",    32'(bus.h_out),     32'(fa.h));
    checkOutput("bp_g_hold",    32'(bus.g_out),     32'(fa.g));
    idleCycles(3);
    checkOutput("bp_din_ready2", 32'(bus.din_ready), 32'd0);
    checkOutput("bp_h_hold2",    32'(bus.h_out),     32'(fa.h));
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp_release_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("bp_release_h",     32'(bus.h_out),     32'(fb.h));
    checkOutput("bp_release_g",     32'(bus.g_out),     32'(fb.g));
    checkOutput("bp_release_perr",  32'(bus.perr),      32'(fb.p));
    checkOutput("bp_release_ready", 32'(bus.din_ready), 32'd1);
    idleCycles(2);

    $display("[TB] gaps between bits");
    sendFrame(8'b01001101, 1'b0, 1, 3);
    checkOutput("gap_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("gap_h",     32'(bus.h_out),     32'hB);
    checkOutput("gap_g",     32'(bus.g_out),     32'h2);
    idleCycles(2);

    $display("[TB] reset mid-frame");
    bus.out_ready = 1'b0;
    sendFrame(8'b01001101, 1'b0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 0);
    rst = 1'b1;
    #1;
    checkOutput("mrst_valid",     32'(bus.out_valid), 32'd0);
    checkOutput("mrst_h",         32'(bus.h_out),     32'd0);
    checkOutput("mrst_g",         32'(bus.g_out),     32'd0);
    checkOutput("mrst_sel",       32'(bus.sel),       32'd0);
    checkOutput("mrst_din_ready", 32'(bus.din_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    sendFrame(8'hC5, 1'b0, 0, 0);
    checkOutput("mrst_new_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("mrst_new_h",     32'(bus.h_out),     32'hB);
    checkOutput("mrst_new_g",     32'(bus.g_out),     32'h8);
    idleCycles(2);

    $display("[TB] randomized frames with random backpressure");
    xferBase = xferCnt;
    fork
      begin
        for (int f = 0; f < 30; f++) begin
          dr = NDATA'($urandom);
          sendFrame(dr, 1'($urandom), 0, 2);
        end
        doneRand = 1'b1;
      end
      begin
        while (!doneRand) begin
          @(posedge clk);
          #1;
          bus.out_ready = 1'($urandom_range(1, 0));
        end
      end
    join
    bus.out_ready = 1'b1;
    idleCycles(6);
    checkOutput("rand_frames", 32'(xferCnt - xferBase), 32'd30);
    checkOutput("drain_empty", 32'(expQ.size()),       32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/demux1to2_deser.md
Name: demux1to2_deser

Overview:
- Receive-side counterpart of the 2:1 mux path. Takes a single serial bit stream and steers alternate bits into two channels, H (even bits) and G (odd bits), using an internal toggling select.
- Reassembles each channel into a WIDTH-bit word.
- Presents the word pair on a valid/ready output.
- Sits downstream of the serialising mux stage and feeds the project's capture/checker logic.

Parameters:
- WIDTH, 4, bits per channel word; one frame = 2*WIDTH data bits; legal range 2..16.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- din  in  1  serial data bit
- din_valid  in  1  din carries a bit this cycle
- din_ready  out  1  block accepts din this cycle (transfer = din_valid & din_ready)
- sel  out  1  current steering bit: 0 = next bit goes to H, 1 = next bit goes to G
- h_out  out  WIDTH  assembled H-channel word
- g_out  out  WIDTH  assembled G-channel word
- out_valid  out  1  h_out/g_out hold a complete frame
- out_ready  in  1  consumer takes the frame (transfer = out_valid & out_ready)
- perr  out  1  parity error flag for the presented frame (see Optional Feature)

Behaviour:
- Reset (async, rst=1) values:
  - sel=0, h_out=0, g_out=0, out_valid=0, perr=0
  - shift registers=0, bit counter=0, state=COLLECT
  - din_ready=0 while rst is high
- Bit order is LSB-first per channel. Frame bit k (k=0..2*WIDTH-1) lands in bit k/2 of h_out when k is even, and of g_out when k is odd.
- sel toggles on every accepted data bit and returns to 0 at each frame start.
- State machine:
  - COLLECT: din_ready=1.
    - Each accepted bit shifts into the H or G shift register per sel; counter increments.
    - On acceptance of the last bit (counter=2*WIDTH-1), if the output register is free (out_valid=0, or out_valid=1 with out_ready=1 in that same cycle): load h_out/g_out, set out_valid=1 the next cycle, clear the counter, stay in COLLECT.
    - Otherwise go to FULL.
  - FULL: din_ready=0; the shift registers hold the completed frame.
    - When out_ready=1, the old frame is consumed. The held frame loads into h_out/g_out in that same edge, out_valid stays 1, and the state returns to COLLECT.
- out_valid falls the cycle after an output transfer, unless a new frame loads on the same edge.
- Latency: out_valid=1 exactly one clock after the final bit is accepted, when the output register is free.
- Throughput: one bit per clock sustained while the consumer keeps out_ready=1. There is no bubble between frames.
- h_out/g_out stay stable while out_valid=1 and out_ready=0.
- din_valid=0 cycles: nothing changes; sel and the counter hold.
- Reset mid-frame: partial frame discarded, sel back to 0, the next accepted bit is frame bit 0.
- A frame whose final bit coincides with an output transfer loads directly; it does not pass through FULL.

Optional Feature:
- Macro: DEMUX_PARITY_CHK_EN.
- Defined:
  - Each frame is 2*WIDTH data bits followed by one even-parity bit. The parity bit is accepted like data but does not toggle sel and is not stored in h_out/g_out.
  - The frame completes on the parity bit.
  - perr is loaded with (XOR of all data bits) ^ (parity bit), alongside h_out/g_out, and is valid while out_valid=1.
- Undefined: the frame is 2*WIDTH bits and perr is tied to 0.

Test Plan:
- WIDTH=4, consumer always ready. Feed bits k0..k7 = 1,0,1,1,0,0,1,0 with din_valid=1.
  - Expect out_valid=1 one clock after k7, with h_out=4'b1011 and g_out=4'b0010.
  - Expect sel to read 0,1,0,1,... on each accepted bit.
- Back-to-back frames, out_ready=1: two frames of 8 bits each with no gap.
  - Expect two out_valid pulses 8 clocks apart and din_ready=1 throughout.
- Backpressure: hold out_ready=0 after frame 1 and stream frame 2.
  - Expect din_ready=0 after frame 2's last bit, with h_out/g_out stable at frame 1.
  - Raise out_ready: frame 2 appears the next clock and din_ready returns to 1.
- Gaps: insert din_valid=0 cycles between every bit of a frame.
  - Expect the same h_out/g_out as the gap-free case and sel frozen during gaps.
- Reset mid-frame: assert rst after 3 bits, release, then send a full frame.
  - Expect all outputs 0 immediately on rst, sel=0, and the new frame decoded correctly with no stale bits.
- With DEMUX_PARITY_CHK_EN: send data 1,0,1,1,0,0,1,0 (four ones).
  - Parity bit 0 → perr=0.
  - Parity bit 1 → perr=1.
  - In both cases h_out=4'b1011 and g_out=4'b0010.
